scan_ring_counter: RTL and testbench
====================================

SCAN_RING_COUNTER -- requirements
Module: scan_ring_counter

Interface
REQ-001 SHALL have parameter N, default 4: number of ring positions (digits); legal range 2..16.
REQ-002 SHALL have parameter PRESCALE, default 1: clk cycles per advance; legal range 1..2^20.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = one-cold output, 0 = one-hot output.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  prescaler count enable.
REQ-007 SHALL have port dir  input  1  0 = index decrements, 1 = index increments.
REQ-008 SHALL have port load  input  1  synchronous position load strobe.
REQ-009 SHALL have port load_idx  input  IW  target position; IW = clog2(N), minimum 1.
REQ-010 SHALL have port Q  output  N  registered ring output, exactly one active bit.
REQ-011 SHALL have port idx  output  IW  registered binary index of the active bit.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse on ring wrap.
REQ-013 SHALL have port err  output  1  registered one-cycle pulse on an illegal load.

Function
REQ-014 SHALL hold a prescaler count pc in range 0..PRESCALE-1; when en=1, pc increments and wraps to 0 after PRESCALE-1; when en=0, pc holds.
REQ-015 SHALL generate internal tick = en AND (pc == PRESCALE-1); with PRESCALE=1, tick = en.
REQ-016 On tick with dir=0, SHALL set idx to (idx-1) mod N, e.g. 0 -> N-1 -> N-2.
REQ-017 On tick with dir=1, SHALL set idx to (idx+1) mod N.
REQ-018 SHALL drive Q bit idx active and all other bits inactive; active = 0 when ACTIVE_LOW=1, 1 when ACTIVE_LOW=0; Q updates in the same edge as idx.
REQ-019 SHALL pulse wrap for one cycle, registered with the idx update, on transitions 0 -> N-1 (dir=0) and N-1 -> 0 (dir=1) caused by tick; wrap SHALL be 0 on load.
REQ-020 On load=1 with load_idx < N, SHALL set idx = load_idx and pc = 0 on the next edge; load SHALL take priority over a simultaneous tick.
REQ-021 On load=1 with load_idx >= N, SHALL leave idx and Q unchanged, pulse err for one cycle, and let pc and tick behave as if load were 0.
REQ-022 SHALL allow dir to change on any cycle; only its value at a tick is used.
REQ-023 SHALL hold all state unchanged when en=0 and load=0.
REQ-024 SHALL never present zero or more than one active Q bit, including after reset and load.

Reset
REQ-025 On reset=0, SHALL immediately and asynchronously set idx=0, pc=0, wrap=0 and err=0, and set Q bit 0 active with all other bits inactive (N=4, ACTIVE_LOW=1: Q=4'b1110).
REQ-026 After release of reset, SHALL resume operation from the reset state on the first clk edge; a reset asserted mid-prescale SHALL discard the partial count.

Configuration
REQ-027 With macro SCAN_RING_BLANK_EN defined, SHALL add port blank  input  1; while blank=1, all Q bits SHALL be inactive, and idx, pc and wrap SHALL continue to operate unaffected.
REQ-028 Without SCAN_RING_BLANK_EN, the blank port SHALL NOT exist, and the REQ-024 invariant SHALL apply unconditionally.

Structure
REQ-029 SHALL import from shared package scan_pkg the clog2 width function and the N/PRESCALE legality constants.
REQ-030 SHALL implement the prescaler (pc, tick, clear-on-load) as sub-module scan_prescaler; the ring and index logic SHALL stay in the top module.

Verification
REQ-031 Reset: N=4, ACTIVE_LOW=1, reset=0 mid-run -> Q=1110, idx=0, wrap=0 immediately, without a clk edge.
REQ-032 Rotation: PRESCALE=3, en=1, dir=0 -> Q changes every 3 clks: 1110, 0111, 1011, 1101, 1110; wrap=1 only with the 0111 update.
REQ-033 Direction and enable: dir=1, PRESCALE=1 -> idx 0,1,2,3,0; en=0 for 5 clks -> idx and pc frozen.
REQ-034 Load: load_idx=2 together with tick -> idx=2, pc=0, wrap=0; load_idx=5 with N=4 -> err pulse, idx unchanged.
REQ-035 Parameters: N=8, ACTIVE_LOW=0 -> one-hot Q, a single 1 walking 8 positions; invariant checked every cycle.
REQ-036 Blank: SCAN_RING_BLANK_EN defined, blank=1 -> Q all inactive while idx advances; blank=0 -> Q matches idx.

Source files
------------

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan ring counter family.
//   clog2()         : index width helper, never returns less than 1
//   N_MIN/N_MAX     : legal range of ring positions
//   PRESCALE_MIN/MAX: legal range of clk cycles per advance
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int unsigned N_MIN        = 2;
  localparam int unsigned N_MAX        = 16;
  localparam int unsigned PRESCALE_MIN = 1;
  localparam int unsigned PRESCALE_MAX = 1 << 20;

  // Bits needed to hold 0..value-1, clamped to at least 1 bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Divides clk down to a one-cycle advance strobe for the ring counter.
// Parameters:
//   PRESCALE : clk cycles per tick (1 gives tick = en)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears the count
//   en    : count enable; count holds while low
//   clr   : synchronous clear of the count (legal position load)
//   tick  : en AND (count == PRESCALE-1), combinational
// -----------------------------------------------------------------------------
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    PW     = clog2(PRESCALE);
  localparam logic [PW-1:0]  PC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pc;

  assign tick = en && (pc == PC_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (clr || tick) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc + PW'(1);
    end
  end

endmodule

// File: rtl/scan_ring_counter.sv
// -----------------------------------------------------------------------------
// scan_ring_counter
// Prescaled bidirectional ring counter for multiplexed digit scanning.
// Exactly one Q bit is active; its position is mirrored in binary on idx.
// Parameters:
//   N          : ring positions, 2..16
//   PRESCALE   : clk cycles per advance, 1..2^20
//   ACTIVE_LOW : 1 = one-cold Q, 0 = one-hot Q
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset (idx=0, Q bit 0 active)
//   blank    : (only with SCAN_RING_BLANK_EN) forces all Q bits inactive
//   en       : prescaler count enable
//   dir      : 1 = idx increments, 0 = idx decrements on a tick
//   load     : synchronous position load strobe
//   load_idx : load target; values >= N are rejected and flagged on err
//   Q        : registered ring output
//   idx      : registered binary index of the active bit
//   wrap     : one-cycle pulse when a tick wraps the ring
//   err      : one-cycle pulse on a rejected load
// Build option: define SCAN_RING_BLANK_EN to add the blank input.
// -----------------------------------------------------------------------------
module scan_ring_counter
  import scan_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
`ifdef SCAN_RING_BLANK_EN
  input  logic                blank,
`endif
  input  logic                en,
  input  logic                dir,
  input  logic                load,
  input  logic [clog2(N)-1:0] load_idx,
  output logic [N-1:0]        Q,
  output logic [clog2(N)-1:0] idx,
  output logic                wrap,
  output logic                err
);

  localparam int unsigned   IW      = clog2(N);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);
  localparam logic          ACT     = (ACTIVE_LOW == 0);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("scan_ring_counter: N out of range");
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("scan_ring_counter: PRESCALE out of range");
  end

  function automatic logic [N-1:0] ring(input logic [IW-1:0] pos);
    logic [N-1:0] r;
    for (int unsigned i = 0; i < N; i++) begin
      r[i] = (IW'(i) == pos) ? ACT : ~ACT;
    end
    return r;
  endfunction

  localparam logic [N-1:0] Q_RST = ring(IW'(0));

  logic          tick;
  logic          load_ok;
  logic [4:0]    load_ext;
  logic [IW-1:0] idx_next;
  logic          wrap_next;
  logic [N-1:0]  ring_q;

  // Widened before comparing so power-of-two N does not yield a constant test.
  assign load_ext = 5'(load_idx);
  assign load_ok  = load && (load_ext < 5'(N));

  // A rejected load leaves the prescaler running as if load were low.
  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load_ok),
    .tick  (tick)
  );

  always_comb begin
    idx_next  = idx;
    wrap_next = 1'b0;
    if (load_ok) begin
      idx_next = load_idx;
    end else if (tick) begin
      if (dir) begin
        if (idx == IDX_MAX) begin
          idx_next  = '0;
          wrap_next = 1'b1;
        end else begin
          idx_next = idx + IW'(1);
        end
      end else begin
        if (idx == '0) begin
          idx_next  = IDX_MAX;
          wrap_next = 1'b1;
        end else begin
          idx_next = idx - IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      ring_q <= Q_RST;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      idx    <= idx_next;
      ring_q <= ring(idx_next);
      wrap   <= wrap_next;
      err    <= load && !load_ok;
    end
  end

`ifdef SCAN_RING_BLANK_EN
  // Blanking masks the output only; the ring register keeps tracking idx.
  assign Q = blank ? {N{~ACT}} : ring_q;
`else
  assign Q = ring_q;
`endif

endmodule

// File: tb/tb_scan_ring_counter.sv
// -----------------------------------------------------------------------------
// tb_scan_ring_counter
// Four instances share clk/reset/en/dir/load; each phase resets all of them
// and checks one instance against hand-derived vector tables.
//   sel 0: N=4 PRESCALE=3 ACTIVE_LOW=1
//   sel 1: N=8 PRESCALE=1 ACTIVE_LOW=0
//   sel 2: N=5 PRESCALE=1 ACTIVE_LOW=1 (non power of two, for rejected loads)
//   sel 3: N=4 PRESCALE=1 ACTIVE_LOW=1
// -----------------------------------------------------------------------------
module tb_scan_ring_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, dir, load;
  logic [1:0] lidx2;
  logic [2:0] lidx3;
`ifdef SCAN_RING_BLANK_EN
  logic       blank;
`endif

  logic [3:0] q_a, q_d;
  logic [7:0] q_b;
  logic [4:0] q_c;
  logic [1:0] idx_a, idx_d;
  logic [2:0] idx_b, idx_c;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;
  logic       err_a, err_b, err_c, err_d;

  scan_ring_counter #(.N(4), .PRESCALE(3), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset),
`ifdef SCAN_RING_BLANK_EN
    .blank(1'b0),
`endif
    .en(en), .dir(dir), .load(load), .load_idx(lidx2),
    .Q(q_a), .idx(idx_a), .wrap(wrap_a), .err(err_a));

  scan_ring_counter #(.N(8), .PRESCALE(1), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset),
`ifdef SCAN_RING_BLANK_EN
    .blank(1'b0),
`endif
    .en(en), .dir(dir), .load(load), .load_idx(lidx3),
    .Q(q_b), .idx(idx_b), .wrap(wrap_b), .err(err_b));

  scan_ring_counter #(.N(5), .PRESCALE(1), .ACTIVE_LOW(1)) dut_c (
    .clk(clk), .reset(reset),
`ifdef SCAN_RING_BLANK_EN
    .blank(1'b0),
`endif
    .en(en), .dir(dir), .load(load), .load_idx(lidx3),
    .Q(q_c), .idx(idx_c), .wrap(wrap_c), .err(err_c));

  scan_ring_counter #(.N(4), .PRESCALE(1), .ACTIVE_LOW(1)) dut_d (
    .clk(clk), .reset(reset),
`ifdef SCAN_RING_BLANK_EN
    .blank(blank),
`endif
    .en(en), .dir(dir), .load(load), .load_idx(lidx2),
    .Q(q_d), .idx(idx_d), .wrap(wrap_d), .err(err_d));

  typedef struct {
    int         sel;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] lidx;
    logic [7:0] q;
    logic [3:0] idx;
    logic       wrap;
    logic       err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input int sel, input logic e, input logic d,
                              input logic l, input logic [3:0] li,
                              input logic [7:0] q, input logic [3:0] ix,
                              input logic w, input logic er);
    vec_t v;
    v.sel = sel; v.en = e; v.dir = d; v.load = l; v.lidx = li;
    v.q = q; v.idx = ix; v.wrap = w; v.err = er;
    return v;
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [7:0] q, output logic [3:0] ix,
                        output logic w, output logic er);
    case (sel)
      0:       begin q = {4'b0, q_a}; ix = {2'b0, idx_a}; w = wrap_a; er = err_a; end
      1:       begin q = q_b;         ix = {1'b0, idx_b}; w = wrap_b; er = err_b; end
      2:       begin q = {3'b0, q_c}; ix = {1'b0, idx_c}; w = wrap_c; er = err_c; end
      default: begin q = {4'b0, q_d}; ix = {2'b0, idx_d}; w = wrap_d; er = err_d; end
    endcase
  endtask

  task automatic compare(input vec_t e, input string tag, input int k);
    logic [7:0] q;
    logic [3:0] ix;
    logic       w, er;
    sample(e.sel, q, ix, w, er);
    check({tag, "_Q"},    k, 32'(q),  32'(e.q));
    check({tag, "_idx"},  k, 32'(ix), 32'(e.idx));
    check({tag, "_wrap"}, k, 32'(w),  32'(e.wrap));
    check({tag, "_err"},  k, 32'(er), 32'(e.err));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run_vec(input vec_t v, input string tag, input int k);
    vec_t e;
    en = v.en; dir = v.dir; load = v.load;
    lidx2 = v.lidx[1:0]; lidx3 = v.lidx[2:0];
    sb.push_back(v);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, k, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      compare(e, tag, k);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], tag, i);
    tbl.delete();
  endtask

  task automatic do_reset;
    en = 1'b0; dir = 1'b0; load = 1'b0; lidx2 = '0; lidx3 = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int         ei, old;
    logic       d, w;
    vec_t       v;
    reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; lidx2 = '0; lidx3 = '0;
`ifdef SCAN_RING_BLANK_EN
    blank = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    compare(mk(0, 0, 0, 0, 0, 8'h0E, 0, 0, 0), "rst_a", 0);
    compare(mk(1, 0, 0, 0, 0, 8'h01, 0, 0, 0), "rst_b", 0);
    compare(mk(2, 0, 0, 0, 0, 8'h1E, 0, 0, 0), "rst_c", 0);
    compare(mk(3, 0, 0, 0, 0, 8'h0E, 0, 0, 0), "rst_d", 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Rotation every 3 clks downward, then loads and enable freeze (sel 0).
    do_reset;
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0E, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h07, 3, 1, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h07, 3, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0B, 2, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0D, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0E, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 2, 8'h0B, 2, 0, 0));   // load on a tick cycle
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0B, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3, 8'h07, 3, 0, 0));   // load mid-prescale clears pc
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 8'h07, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0B, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0B, 2, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, i[0], 0, 0, 8'h0B, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h0B, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0D, 1, 0, 0));
    run_table("rot_a");

    // Asynchronous reset mid-prescale: no edge needed, partial count discarded.
    run_vec(mk(0, 1, 0, 0, 0, 8'h0D, 1, 0, 0), "arst_pre", 0);
    #3 reset = 1'b0;
    #1;
    compare(mk(0, 0, 0, 0, 0, 8'h0E, 0, 0, 0), "arst_now", 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0E, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h0E, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h07, 3, 1, 0));
    run_table("arst_post");

    // Upward count, freeze, downward wrap, load beating a wrap (sel 3).
    do_reset;
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'h0B, 2, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'h07, 3, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'h0E, 0, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(3, 0, 1, 0, 0, 8'h0E, 0, 0, 0));
    tbl.push_back(mk(3, 1, 0, 0, 0, 8'h07, 3, 1, 0));
    tbl.push_back(mk(3, 1, 1, 1, 1, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'h0B, 2, 0, 0));
    run_table("dir_d");

    // Rejected loads on a non power-of-two ring (sel 2).
    do_reset;
    tbl.push_back(mk(2, 0, 0, 1, 5, 8'h1E, 0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 0, 8'h1E, 0, 0, 0));
    tbl.push_back(mk(2, 1, 1, 1, 7, 8'h1D, 1, 0, 1));   // tick still advances
    tbl.push_back(mk(2, 1, 1, 1, 4, 8'h0F, 4, 0, 0));
    tbl.push_back(mk(2, 1, 1, 0, 0, 8'h1E, 0, 1, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 8'h0F, 4, 1, 0));
    run_table("err_c");

    // One-hot walk across 8 positions, up then down, invariant every cycle.
    do_reset;
    ei = 0;
    for (int k = 0; k < 16; k++) begin
      d   = (k < 8);
      old = ei;
      ei  = d ? (ei + 1) % 8 : (ei + 7) % 8;
      w   = (d && old == 7) || (!d && old == 0);
      v   = mk(1, 1, d, 0, 0, 8'(8'h01 << ei), 4'(ei), w, 0);
      run_vec(v, "walk_b", k);
      check("onehot_b", k, 32'($countones(q_b)), 32'(1));
    end

`ifdef SCAN_RING_BLANK_EN
    // Blanking hides Q while the index keeps moving (sel 3).
    do_reset;
    blank = 1'b1;
    for (int k = 1; k <= 4; k++) run_vec(mk(3, 1, 1, 0, 0, 8'h0F, 4'(k % 4), k == 4, 0), "blank_on", k);
    blank = 1'b0;
    #1;
    compare(mk(3, 0, 0, 0, 0, 8'h0E, 0, 0, 0), "blank_off", 0);
    run_vec(mk(3, 1, 1, 0, 0, 8'h0D, 1, 0, 0), "blank_off", 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
